regfile_write_arbiter: RTL and testbench

Arbitrates the register file's single write port between the in-order pipeline write-back stage and the multi-cycle load/store unit. Pipeline writes always win and pass through with zero latency. Load results that lose arbitration are held in a small FIFO until a free slot appears. A starvation counter forces a one-cycle pipeline stall so buffered loads always drain, and an optional scoreboard flags reads of registers whose load is still pending.

---
 rtl/regfile_write_arbiter_if.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Signal bundle between the write-port arbiter and its clients: pipeline write-back,
// load-unit results, register-file write port, stall request and scoreboard read checks.
interface regfile_write_arbiter_if;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 32;

  logic              wb_en;
  logic [IDX_W-1:0]  wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              ld_valid;
  logic [IDX_W-1:0]  ld_dest;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              rf_we;
  logic [IDX_W-1:0]  rf_dest;
  logic [DATA_W-1:0] rf_data;
  logic              pipe_stall;
  logic [IDX_W-1:0]  src1;
  logic [IDX_W-1:0]  src2;
  logic              busy1;
  logic              busy2;

  modport master (
    output wb_en, wb_dest, wb_data, ld_valid, ld_dest, ld_data, src1, src2,
    input  ld_ready, rf_we, rf_dest, rf_data, pipe_stall, busy1, busy2
  );

  modport slave (
    input  wb_en, wb_dest, wb_data, ld_valid, ld_dest, ld_data, src1, src2,
    output ld_ready, rf_we, rf_dest, rf_data, pipe_stall, busy1, busy2
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline write-back (always wins) and a
// load-result FIFO with starvation stall. RF_ARB_SCOREBOARD_EN enables the busy1/busy2 scoreboard.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave arb_if
);
  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = $clog2(MAX_WAIT + 1);
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam logic [IDX_W-1:0] NO_REG = 4'd15;

  logic [PW:0]        wr_ptr_q, wr_ptr_d;
  logic [PW:0]        rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [IDX_W-1:0]   dest_q [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [CW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]      cnt_inc;
  logic               pipe_stall_q, pipe_stall_d;

  logic [PW-1:0]      wr_idx, rd_idx;
  logic               fifo_empty, fifo_full, head_vld;
  logic               wb_win, head_pop, blocked;
  logic               ld_acc, ld_bypass, push;

  logic               rf_we;
  logic [IDX_W-1:0]   rf_dest;
  logic [DATA_W-1:0]  rf_data;

  // Slot decode: pipeline first, then FIFO head, then an empty-FIFO bypass.
  always_comb begin
    wr_idx     = wr_ptr_q[PW-1:0];
    rd_idx     = rd_ptr_q[PW-1:0];
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
    head_vld   = !fifo_empty && vld_q[rd_idx];
    wb_win     = arb_if.wb_en && (arb_if.wb_dest != NO_REG);
    // A superseded head leaves even while the pipeline owns the port.
    head_pop   = !fifo_empty && (!head_vld || !wb_win);
    blocked    = head_vld && wb_win;
    ld_acc     = arb_if.ld_valid && (!fifo_full || head_pop);
    ld_bypass  = ld_acc && fifo_empty && !wb_win;
    push       = ld_acc && !ld_bypass && (arb_if.ld_dest != NO_REG);
  end

  always_comb begin
    rf_we   = 1'b0;
    rf_dest = '0;
    rf_data = '0;
    if (rst) begin
      rf_we = 1'b0;
    end else if (wb_win) begin
      rf_we   = 1'b1;
      rf_dest = arb_if.wb_dest;
      rf_data = arb_if.wb_data;
    end else if (head_vld) begin
      rf_we   = 1'b1;
      rf_dest = dest_q[rd_idx];
      rf_data = data_q[rd_idx];
    end else if (ld_bypass && (arb_if.ld_dest != NO_REG)) begin
      rf_we   = 1'b1;
      rf_dest = arb_if.ld_dest;
      rf_data = arb_if.ld_data;
    end
  end

  // FIFO pointer/valid update; the same-cycle push is younger than any supersede.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    if (head_pop) begin
      vld_d[rd_idx] = 1'b0;
      rd_ptr_d      = rd_ptr_q + (PW+1)'(1);
    end
    if (wb_win) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (dest_q[i] == arb_if.wb_dest) vld_d[i] = 1'b0;
      end
    end
    if (push) begin
      vld_d[wr_idx] = 1'b1;
      wr_ptr_d      = wr_ptr_q + (PW+1)'(1);
    end
  end

  // Starvation: a head blocked long enough forces a one-cycle stall; a stall overridden
  // by the pipeline re-arms immediately.
  always_comb begin
    cnt_inc      = wait_cnt_q + CW'(1);
    wait_cnt_d   = '0;
    pipe_stall_d = 1'b0;
    if (blocked) begin
      if (pipe_stall_q || (MAX_WAIT < 2) || (cnt_inc == CW'(MAX_WAIT - 1))) begin
        pipe_stall_d = 1'b1;
      end else begin
        wait_cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      vld_q        <= '0;
      wait_cnt_q   <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      vld_q        <= vld_d;
      wait_cnt_q   <= wait_cnt_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

  // Payload storage needs no reset: contents only matter behind a set valid bit.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_idx] <= arb_if.ld_dest;
      data_q[wr_idx] <= arb_if.ld_data;
    end
  end

  assign arb_if.ld_ready   = !fifo_full || head_pop;
  assign arb_if.rf_we      = rf_we;
  assign arb_if.rf_dest    = rf_dest;
  assign arb_if.rf_data    = rf_data;
  assign arb_if.pipe_stall = pipe_stall_q;

`ifdef RF_ARB_SCOREBOARD_EN
  logic busy1, busy2;

  // An entry being written this cycle is still pending, so vld_q (not vld_d) is used.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (dest_q[i] == arb_if.src1) && (arb_if.src1 != NO_REG)) busy1 = 1'b1;
      if (vld_q[i] && (dest_q[i] == arb_if.src2) && (arb_if.src2 != NO_REG)) busy2 = 1'b1;
    end
  end

  assign arb_if.busy1 = busy1;
  assign arb_if.busy2 = busy2;
`else
  logic unused_src;

  assign unused_src   = ^{arb_if.src1, arb_if.src2};
  assign arb_if.busy1 = 1'b0;
  assign arb_if.busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, multi-cycle corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  typedef struct {
    bit        wb_en;
    bit [3:0]  wb_dest;
    bit [31:0] wb_data;
    bit        ld_valid;
    bit [3:0]  ld_dest;
    bit [31:0] ld_data;
    bit [3:0]  src1;
    bit [3:0]  src2;
  } stim_t;

  typedef struct {
    stim_t     s;
    bit        we;
    bit [3:0]  dest;
    bit [31:0] data;
    bit        ready;
  } vec_t;

  typedef struct {
    bit [3:0]  dest;
    bit [31:0] data;
    bit        vld;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .arb_if (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: queue of buffered loads plus a blocked-cycle run length.
  ent_t      mq[$];
  int        run_len = 0;
  bit        m_stall = 1'b0;
  stim_t     cur;
  bit        m_pop, m_push, m_blocked;
  bit        e_we, e_ready, e_b1, e_b2;
  bit [3:0]  e_dest;
  bit [31:0] e_data;
  vec_t      tv[14];
  stim_t     idle;

  function automatic void model_reset();
    mq.delete();
    run_len = 0;
    m_stall = 1'b0;
  endfunction

  function automatic bit pending(input bit [3:0] idx);
    if (idx == 4'd15) return 1'b0;
    foreach (mq[i]) if (mq[i].vld && mq[i].dest == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_eval();
    bit wbw  = cur.wb_en && (cur.wb_dest != 4'd15);
    bit have = (mq.size() > 0);
    bit hv   = have && mq[0].vld;
    m_pop     = have && (!hv || !wbw);
    m_blocked = hv && wbw;
    e_ready   = (mq.size() < DEPTH) || m_pop;
    e_we = 1'b0; e_dest = '0; e_data = '0;
    if (wbw) begin
      e_we = 1'b1; e_dest = cur.wb_dest; e_data = cur.wb_data;
    end else if (hv) begin
      e_we = 1'b1; e_dest = mq[0].dest; e_data = mq[0].data;
    end else if (!have && cur.ld_valid && cur.ld_dest != 4'd15) begin
      e_we = 1'b1; e_dest = cur.ld_dest; e_data = cur.ld_data;
    end
    m_push = cur.ld_valid && e_ready && (cur.ld_dest != 4'd15) && !(!have && !wbw);
`ifdef RF_ARB_SCOREBOARD_EN
    e_b1 = pending(cur.src1);
    e_b2 = pending(cur.src2);
`else
    e_b1 = 1'b0;
    e_b2 = 1'b0;
`endif
  endfunction

  function automatic void model_update();
    bit wbw = cur.wb_en && (cur.wb_dest != 4'd15);
    bit nxt;
    if (m_pop) void'(mq.pop_front());
    if (wbw) foreach (mq[i]) if (mq[i].dest == cur.wb_dest) mq[i].vld = 1'b0;
    if (m_push) mq.push_back('{dest: cur.ld_dest, data: cur.ld_data, vld: 1'b1});
    nxt = m_blocked && (m_stall || (run_len + 1 >= MAX_WAIT - 1));
    if (nxt || !m_blocked) run_len = 0;
    else run_len = run_len + 1;
    m_stall = nxt;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    cur          = s;
    bus.wb_en    = s.wb_en;
    bus.wb_dest  = s.wb_dest;
    bus.wb_data  = s.wb_data;
    bus.ld_valid = s.ld_valid;
    bus.ld_dest  = s.ld_dest;
    bus.ld_data  = s.ld_data;
    bus.src1     = s.src1;
    bus.src2     = s.src2;
  endtask

  // Drive one cycle's inputs, predict, and compare on the falling edge.
  task automatic sample(input stim_t s);
    apply(s);
    model_eval();
    @(negedge clk);
    check("rf_we",      32'(bus.rf_we),      32'(e_we));
    check("rf_dest",    32'(bus.rf_dest),    32'(e_dest));
    check("rf_data",    bus.rf_data,         e_data);
    check("ld_ready",   32'(bus.ld_ready),   32'(e_ready));
    check("pipe_stall", 32'(bus.pipe_stall), 32'(m_stall));
    check("busy1",      32'(bus.busy1),      32'(e_b1));
    check("busy2",      32'(bus.busy2),      32'(e_b2));
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    32'(bus.rf_we),      32'd0);
    check({tag, "_dest"},  32'(bus.rf_dest),    32'd0);
    check({tag, "_data"},  bus.rf_data,         32'd0);
    check({tag, "_stall"}, 32'(bus.pipe_stall), 32'd0);
    check({tag, "_ready"}, 32'(bus.ld_ready),   32'd1);
    check({tag, "_busy1"}, 32'(bus.busy1),      32'd0);
    check({tag, "_busy2"}, 32'(bus.busy2),      32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    stim_t s;
    int    ld_i;

    idle = '{default: '0};
    // {wb_en, wb_dest, wb_data, ld_valid, ld_dest, ld_data, src1, src2}, we, dest, data, ready
    tv[0]  = '{'{0, 0, 32'h0,   0, 0,  32'h0,  0, 0}, 0, 0, 32'h0,   1};
    tv[1]  = '{'{0, 0, 32'h0,   1, 3,  32'hAA, 0, 0}, 1, 3, 32'hAA,  1};
    tv[2]  = '{'{1, 1, 32'h100, 1, 2,  32'h200, 0, 0}, 1, 1, 32'h100, 1};
    tv[3]  = '{'{0, 0, 32'h0,   0, 0,  32'h0,  0, 0}, 1, 2, 32'h200, 1};
    tv[4]  = '{'{0, 0, 32'h0,   0, 0,  32'h0,  0, 0}, 0, 0, 32'h0,   1};
    tv[5]  = '{'{1, 7, 32'h77,  1, 5,  32'h11, 0, 0}, 1, 7, 32'h77,  1};
    tv[6]  = '{'{1, 5, 32'h22,  0, 0,  32'h0,  0, 0}, 1, 5, 32'h22,  1};
    tv[7]  = '{'{0, 0, 32'h0,   0, 0,  32'h0,  0, 0}, 0, 0, 32'h0,   1};
    tv[8]  = '{'{0, 0, 32'h0,   0, 0,  32'h0,  0, 0}, 0, 0, 32'h0,   1};
    tv[9]  = '{'{0, 0, 32'h0,   1, 15, 32'h5,  0, 0}, 0, 0, 32'h0,   1};
    tv[10] = '{'{1, 15, 32'h9,  0, 0,  32'h0,  0, 0}, 0, 0, 32'h0,   1};
    tv[11] = '{'{1, 15, 32'h9,  1, 4,  32'h44, 0, 0}, 1, 4, 32'h44,  1};
    tv[12] = '{'{1, 2, 32'h33,  1, 15, 32'h1,  0, 0}, 1, 2, 32'h33,  1};
    tv[13] = '{'{0, 0, 32'h0,   0, 0,  32'h0,  0, 0}, 0, 0, 32'h0,   1};

    apply(idle);
    #2;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      sample(tv[i].s);
      check($sformatf("tv%0d_we", i),    32'(bus.rf_we),      32'(tv[i].we));
      check($sformatf("tv%0d_dest", i),  32'(bus.rf_dest),    32'(tv[i].dest));
      check($sformatf("tv%0d_data", i),  bus.rf_data,         tv[i].data);
      check($sformatf("tv%0d_ready", i), 32'(bus.ld_ready),   32'(tv[i].ready));
      check($sformatf("tv%0d_stall", i), 32'(bus.pipe_stall), 32'd0);
      advance();
    end

    // Fill under continuous write-back; the pipeline honours pipe_stall.
    ld_i = 0;
    for (int c = 0; c < 16; c++) begin
      s          = idle;
      s.wb_en    = !m_stall;
      s.wb_dest  = 4'd1;
      s.wb_data  = 32'(c);
      s.ld_valid = (ld_i < 5);
      s.ld_dest  = 4'(8 + ld_i);
      s.ld_data  = 32'h500 + 32'(ld_i);
      s.src1     = 4'd8;
      s.src2     = 4'd15;
      sample(s);
      if (c == 4) check("fill_ready_full", 32'(bus.ld_ready), 32'd0);
      if (c == MAX_WAIT - 1) check("stall_before", 32'(bus.pipe_stall), 32'd0);
      if (c == MAX_WAIT) begin
        check("stall_at_maxwait", 32'(bus.pipe_stall), 32'd1);
        check("drain_we",         32'(bus.rf_we),      32'd1);
        check("drain_dest",       32'(bus.rf_dest),    32'd8);
        check("drain_data",       bus.rf_data,         32'h500);
        check("drain_ready",      32'(bus.ld_ready),   32'd1);
      end
      if (s.ld_valid && e_ready) ld_i++;
      advance();
    end

    for (int c = 0; c < 12; c++) begin
      sample(idle);
      advance();
    end

    // Three buffered entries, then a reset in the middle of a cycle.
    for (int c = 0; c < 3; c++) begin
      s          = idle;
      s.wb_en    = 1'b1;
      s.wb_dest  = 4'd1;
      s.wb_data  = 32'h900 + 32'(c);
      s.ld_valid = 1'b1;
      s.ld_dest  = 4'(4 + c);
      s.ld_data  = 32'hC00 + 32'(c);
      s.src1     = 4'd5;
      sample(s);
      advance();
    end
    s      = idle;
    s.src1 = 4'd5;
    apply(s);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      sample(s);
      check("post_rst_we", 32'(bus.rf_we), 32'd0);
      advance();
    end

    // Random traffic on a small register set so supersedes and stalls are frequent.
    for (int n = 0; n < 800; n++) begin
      s          = idle;
      s.wb_en    = ($urandom_range(0, 99) < 70);
      if (m_stall && ($urandom_range(0, 1) == 0)) s.wb_en = 1'b0;
      s.wb_dest  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      s.wb_data  = $urandom;
      s.ld_valid = ($urandom_range(0, 99) < 55);
      s.ld_dest  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      s.ld_data  = $urandom;
      s.src1     = 4'($urandom_range(0, 7));
      s.src2     = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      sample(s);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
